alu_issue: RTL and testbench

Sequencing stage directly upstream of the ALU. It accepts one arithmetic request at a time over a valid/ready handshake and drives the ALU operand and opcode inputs for exactly one clock. It then captures the ALU's registered result and Z/Y flags, and returns them over a second valid/ready handshake. Illegal opcodes and divide-class operations with a zero divisor are rejected before they reach the ALU.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_op_check.sv | 20 ++
 rtl/alu_issue.sv | 108 ++++++++++
 tb/tb_alu_issue.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the ALU issue stage.
// Pure declarations; no latency and no backpressure involved.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned OPW_DEF   = 4;

  localparam int unsigned ALU_NOP   = 0;
  localparam int unsigned ALU_ADD   = 1;
  localparam int unsigned ALU_ADD1  = 2;
  localparam int unsigned ALU_SUB   = 3;
  localparam int unsigned ALU_SUB1  = 4;
  localparam int unsigned ALU_MUL   = 5;
  localparam int unsigned ALU_ROOF  = 6;
  localparam int unsigned ALU_FLOOR = 7;
  localparam int unsigned ALU_MOD   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Divide-class ops cannot take a zero divisor.
  function automatic logic is_div_class(input int unsigned op);
    return (op == ALU_ROOF) || (op == ALU_FLOOR) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request, response and ALU-side signals of the issue stage, with requester (master) and stage (slave) views.
// Wiring only; handshakes are valid/ready on both the request and response sides.
interface alu_issue_if import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_in_1;
  logic [WIDTH-1:0] alu_in_2;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_y;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_z;
  logic             rsp_y;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_z, alu_y,
    input  req_ready, alu_in_1, alu_in_2, alu_op, rsp_valid, rsp_data, rsp_z, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_z, alu_y,
    output req_ready, alu_in_1, alu_in_2, alu_op, rsp_valid, rsp_data, rsp_z, rsp_y, rsp_err
  );
endinterface

// File: rtl/alu_op_check.sv
// Combinational legality check of an opcode/divisor pair before it may reach the ALU.
// Zero latency; no handshake.
module alu_op_check import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] b,
  output logic             legal
);

  int unsigned op_u;

  always_comb begin
    op_u  = 32'(op);
    legal = (op_u != ALU_NOP) && (op_u <= ALU_MOD)
            && !(is_div_class(op_u) && (b == '0));
  end

endmodule

// File: rtl/alu_issue.sv
// Sequences one request into the ALU for one cycle, captures its registered result, returns it.
// Legal: response 2 edges after accept; illegal: same edge. Holds the response until rsp_ready; one request in flight.
module alu_issue import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic      Clock,
  input  logic      Reset_n,
  alu_issue_if.slave bus
);

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] alu_in_1_q, alu_in_1_d;
  logic [WIDTH-1:0] alu_in_2_q, alu_in_2_d;
  logic [OPW-1:0]   alu_op_q,   alu_op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_z_q,    rsp_z_d;
  logic             rsp_y_q,    rsp_y_d;
  logic             rsp_err_q,  rsp_err_d;
  logic             op_legal;

  alu_op_check #(.WIDTH(WIDTH), .OPW(OPW)) u_op_check (
    .op    (bus.req_op),
    .b     (bus.req_b),
    .legal (op_legal)
  );

  always_comb begin
    state_d    = state_q;
    alu_in_1_d = alu_in_1_q;
    alu_in_2_d = alu_in_2_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_z_d    = rsp_z_q;
    rsp_y_d    = rsp_y_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          alu_in_1_d = bus.req_a;
          alu_in_2_d = bus.req_b;
          if (op_legal) begin
            alu_op_d = bus.req_op;
            state_d  = ST_ISSUE;
          end else begin
            // Rejected requests skip the ALU and answer immediately.
            rsp_data_d = '0;
            rsp_z_d    = 1'b0;
            rsp_y_d    = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        alu_op_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // ALU outputs settled on the edge that left ISSUE.
        rsp_data_d = bus.alu_out;
        rsp_z_d    = bus.alu_z;
        rsp_y_d    = bus.alu_y;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      alu_in_1_q <= '0;
      alu_in_2_q <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
      rsp_y_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_in_1_q <= alu_in_1_d;
      alu_in_2_q <= alu_in_2_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_z_q    <= rsp_z_d;
      rsp_y_q    <= rsp_y_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.alu_in_1  = alu_in_1_q;
  assign bus.alu_in_2  = alu_in_2_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: an ALU stand-in, a transaction-level expectation model with a per-cycle
// compare process, and hand-computed literal expectations for each directed request.
module tb_alu_issue;
  import alu_pkg::*;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clock = ~Clock;

  alu_issue_if #(.WIDTH(16), .OPW(4)) bus ();
  alu_issue    #(.WIDTH(16), .OPW(4)) dut (.Clock(Clock), .Reset_n(Reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic the ALU performs; prev is the value ALUOut keeps when it does not update.
  function automatic void alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] prev, output logic [15:0] d,
                                  output logic z, output logic y);
    logic [31:0] wide;
    d = prev; z = 1'b0; y = 1'b0; wide = 32'd0;
    case (op)
      4'd1: d = a + b;
      4'd2: d = a + 16'd1;
      4'd3: if (a < b) y = 1'b1; else begin d = a - b; z = (a == b); end
      4'd4: d = a - 16'd1;
      4'd5: d = a * b;
      4'd6: if (b != 0) begin wide = (32'(a) + 32'(b) - 32'd1) / 32'(b); d = wide[15:0]; end
      4'd7: if (b != 0) d = a / b;
      4'd8: if (b != 0) d = a % b;
      default: ;
    endcase
  endfunction

  // ALU stand-in: registered outputs, no reset, samples only while alu_op is non-zero.
  logic [15:0] stub_out = 16'hDEAD;
  logic        stub_z   = 1'b0;
  logic        stub_y   = 1'b0;
  assign bus.alu_out = stub_out;
  assign bus.alu_z   = stub_z;
  assign bus.alu_y   = stub_y;
  initial forever begin
    logic [15:0] d; logic z, y;
    @(posedge Clock);
    if (bus.alu_op != 4'd0) begin
      alu_ref(bus.alu_op, bus.alu_in_1, bus.alu_in_2, stub_out, d, z, y);
      stub_out = d; stub_z = z; stub_y = y;
    end
  end

  int op_cyc = 0;
  initial forever begin
    @(negedge Clock);
    if (bus.alu_op != 4'd0) op_cyc++;
  end

  // Transaction model: one request in flight, timestamps for issue and response.
  int          m_edge = 0, m_rsp_edge = 0, m_acc_edge = -10;
  bit          m_busy = 1'b0, m_legal = 1'b0;
  logic [3:0]  m_op = 4'd0;
  logic [15:0] m_in1 = 16'd0, m_in2 = 16'd0, m_d = 16'd0;
  logic        m_z = 1'b0, m_y = 1'b0, m_err = 1'b0;

  initial forever begin
    @(posedge Clock or negedge Reset_n);
    if (!Reset_n) begin
      m_busy = 1'b0; m_legal = 1'b0; m_acc_edge = -10; m_op = 4'd0;
      m_in1 = 16'd0; m_in2 = 16'd0; m_d = 16'd0; m_z = 1'b0; m_y = 1'b0; m_err = 1'b0;
    end else begin
      m_edge++;
      if (m_busy) begin
        if (m_edge - 1 >= m_rsp_edge && bus.rsp_ready) m_busy = 1'b0;
      end else if (bus.req_valid) begin
        m_busy     = 1'b1;
        m_acc_edge = m_edge;
        m_op       = bus.req_op;
        m_in1      = bus.req_a;
        m_in2      = bus.req_b;
        m_legal    = (m_op >= 4'd1) && (m_op <= 4'd8) && !(m_op >= 4'd6 && m_in2 == 16'd0);
        if (m_legal) begin
          alu_ref(m_op, m_in1, m_in2, 16'd0, m_d, m_z, m_y);
          m_err      = 1'b0;
          m_rsp_edge = m_edge + 2;
        end else begin
          m_d = 16'd0; m_z = 1'b0; m_y = 1'b0; m_err = 1'b1;
          m_rsp_edge = m_edge;
        end
      end
    end
  end

  initial forever begin
    bit          e_rvld;
    logic [3:0]  e_op;
    @(posedge Clock);
    #2;
    e_rvld = m_busy && (m_edge >= m_rsp_edge);
    e_op   = (m_busy && m_legal && m_edge == m_acc_edge) ? m_op : 4'd0;
    chk("cyc_req_ready", 32'(bus.req_ready), 32'(!m_busy));
    chk("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(e_rvld));
    chk("cyc_alu_op",    32'(bus.alu_op),    32'(e_op));
    chk("cyc_alu_in_1",  32'(bus.alu_in_1),  32'(m_in1));
    chk("cyc_alu_in_2",  32'(bus.alu_in_2),  32'(m_in2));
    if (e_rvld) begin
      if (!m_y) chk("cyc_rsp_data", 32'(bus.rsp_data), 32'(m_d));
      chk("cyc_rsp_z",   32'(bus.rsp_z),   32'(m_z));
      chk("cyc_rsp_y",   32'(bus.rsp_y),   32'(m_y));
      chk("cyc_rsp_err", 32'(bus.rsp_err), 32'(m_err));
    end
  end

  // Called and returning at a falling edge; returns at the falling edge right after acceptance.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int waited);
    waited = 0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    while (!bus.req_ready && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    chk("send_accept", 32'(bus.req_ready), 32'd1);
    @(negedge Clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [15:0] d, output logic z, output logic y,
                         output logic err, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge Clock);
      lat++;
    end
    chk("rsp_arrive", 32'(bus.rsp_valid), 32'd1);
    d = bus.rsp_data; z = bus.rsp_z; y = bus.rsp_y; err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data",  32'(bus.rsp_data),  32'(d));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge Clock);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic ez, input logic ey, input logic eerr,
                        input int elat, input int eopc, input bit chk_d);
    logic [15:0] d; logic z, y, err; int lat, waited, base;
    base = op_cyc;
    send(op, a, b, waited);
    chk({nm, "_alu_op"}, 32'(bus.alu_op), eopc != 0 ? 32'(op) : 32'd0);
    get_rsp(0, d, z, y, err, lat);
    if (chk_d) chk({nm, "_data"}, 32'(d), 32'(ed));
    chk({nm, "_z"},       32'(z),   32'(ez));
    chk({nm, "_y"},       32'(y),   32'(ey));
    chk({nm, "_err"},     32'(err), 32'(eerr));
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_issues"},  32'(op_cyc - base), 32'(eopc));
  endtask

  initial begin
    logic [15:0] d; logic z, y, err; int lat, waited, base;
    bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 16'd0; bus.req_b = 16'd0;
    bus.rsp_ready = 1'b0;
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_rsp_flags", {29'd0, bus.rsp_z, bus.rsp_y, bus.rsp_err}, 32'd0);
    chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("rst_alu_in",    {bus.alu_in_1, bus.alu_in_2}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    do_txn("add",      4'd1, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1);
    do_txn("sub_eq",   4'd3, 16'h0010, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1);
    do_txn("sub_bor",  4'd3, 16'h0002, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 1, 1'b0);
    do_txn("roof",     4'd6, 16'd7,    16'd2,    16'd4,    1'b0, 1'b0, 1'b0, 2, 1, 1'b1);
    do_txn("floor",    4'd7, 16'd7,    16'd2,    16'd3,    1'b0, 1'b0, 1'b0, 2, 1, 1'b1);
    do_txn("mod",      4'd8, 16'd7,    16'd2,    16'd1,    1'b0, 1'b0, 1'b0, 2, 1, 1'b1);
    do_txn("mod_zero", 4'd8, 16'd7,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1, 0, 0, 1'b1);

    // Backpressure with a competing request held throughout.
    base = op_cyc;
    send(4'd5, 16'h0100, 16'h0100, waited);
    bus.req_valid = 1'b1; bus.req_op = 4'd1; bus.req_a = 16'h0001; bus.req_b = 16'h0002;
    get_rsp(5, d, z, y, err, lat);
    chk("bp_mul_data",    32'(d),   32'h0000);
    chk("bp_mul_err",     32'(err), 32'd0);
    chk("bp_mul_latency", 32'(lat), 32'd2);
    chk("bp_mul_issues",  32'(op_cyc - base), 32'd1);
    chk("bp_in1_held",    32'(bus.alu_in_1), 32'h0100);
    send(4'd1, 16'h0001, 16'h0002, waited);
    chk("bp_next_wait",   32'(waited), 32'd0);
    get_rsp(0, d, z, y, err, lat);
    chk("bp_next_data",   32'(d), 32'h0003);

    do_txn("bad_op",   4'hF, 16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    do_txn("sub1_0",   4'd4, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1);

    // Asynchronous reset while the ALU is being driven.
    send(4'd1, 16'h0005, 16'h0006, waited);
    chk("mid_issue_op", 32'(bus.alu_op), 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("arst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("arst_alu_in",    {bus.alu_in_1, bus.alu_in_2}, 32'd0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("arst_rsp_flags", {29'd0, bus.rsp_z, bus.rsp_y, bus.rsp_err}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    do_txn("post_rst", 4'd1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1);

    repeat (2) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
